// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, FSM state type and the small sigma helpers
// used by both the message schedule and the round engine.
package sha256_pkg;

  localparam int SHA256_WORD_W = 32;
  localparam int SHA256_ROUNDS = 64;
  localparam int SHA256_IDX_W  = 6;

  typedef logic [SHA256_WORD_W-1:0] word_t;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } sched_state_e;

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (SHA256_WORD_W - n));
  endfunction

  function automatic word_t sig0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t sig1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_w_expand.sv
// Combinational schedule expansion:
// W[t] = sig1(W[t-2]) + W[t-7] + sig0(W[t-15]) + W[t-16] (mod 2^32).
module sha256_w_expand
  import sha256_pkg::*;
(
  input  word_t w_t2,
  input  word_t w_t7,
  input  word_t w_t15,
  input  word_t w_t16,
  output word_t w_t
);

  assign w_t = sig1(w_t2) + w_t7 + sig0(w_t15) + w_t16;

endmodule

// File: rtl/sha256_message_schedule.sv
// SHA-256 message schedule: takes one padded 512-bit block and streams W[0..63].
// Optional consumer back-pressure (w_ready port) is enabled by SHA256_W_READY_EN.
//
// state | meaning
// IDLE  | waiting for a block, block_ready high
// EMIT  | streaming W[w_idx], w_valid high until the t=63 beat is taken
module sha256_message_schedule
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [511:0] block_in,
  input  logic         block_valid,
  output logic         block_ready,
  output logic [31:0]  w_out,
  output logic         w_valid,
  output logic [5:0]   w_idx,
  output logic         sched_done
`ifdef SHA256_W_READY_EN
  ,
  input  logic         w_ready
`endif
);

  localparam logic [SHA256_IDX_W-1:0] LAST_IDX = SHA256_IDX_W'(SHA256_ROUNDS - 1);

  sched_state_e state, state_nxt;
  word_t        window [16];
  word_t        w_new;
  logic         accept;
  logic         beat_acc;
  logic         last_beat;

  assign accept = block_valid & block_ready;

`ifdef SHA256_W_READY_EN
  assign beat_acc = w_valid & w_ready;
`else
  assign beat_acc = w_valid;
`endif

  assign last_beat = beat_acc && (w_idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    block_ready = 1'b0;
    w_valid     = 1'b0;
    sched_done  = 1'b0;
    case (state)
      IDLE: begin
        block_ready = 1'b1;
        if (accept) state_nxt = EMIT;
      end
      EMIT: begin
        w_valid    = 1'b1;
        sched_done = (w_idx == LAST_IDX);
        if (last_beat) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Once W[15] is on the output, window[0..15] holds W[t-15..t], so the
  // taps for W[t+1] sit at fixed positions.
  sha256_w_expand u_expand (
    .w_t2  (window[14]),
    .w_t7  (window[9]),
    .w_t15 (window[1]),
    .w_t16 (window[0]),
    .w_t   (w_new)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) window[i] <= '0;
      w_out <= '0;
      w_idx <= '0;
    end else if (accept) begin
      for (int i = 0; i < 16; i++) window[i] <= block_in[511 - 32*i -: 32];
      w_out <= block_in[511:480];
      w_idx <= '0;
    end else if (beat_acc && !last_beat) begin
      w_idx <= w_idx + 6'd1;
      if (w_idx < 6'd15) begin
        w_out <= window[w_idx[3:0] + 4'd1];
      end else begin
        w_out <= w_new;
        for (int i = 0; i < 15; i++) window[i] <= window[i+1];
        window[15] <= w_new;
      end
    end
  end

endmodule
